// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Shared 640x480@60 raster constants, coordinate type and helper.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int c_h_visible = 640;
    localparam int c_h_front   = 16;
    localparam int c_h_sync    = 96;
    localparam int c_h_back    = 48;
    localparam int c_h_total   = c_h_visible + c_h_front + c_h_sync + c_h_back;

    localparam int c_v_visible = 480;
    localparam int c_v_front   = 10;
    localparam int c_v_sync    = 2;
    localparam int c_v_back    = 33;
    localparam int c_v_total   = c_v_visible + c_v_front + c_v_sync + c_v_back;

    // Sync windows are half-open: [start, end)
    localparam int c_h_sync_start = c_h_visible + c_h_front;
    localparam int c_h_sync_end   = c_h_sync_start + c_h_sync;
    localparam int c_v_sync_start = c_v_visible + c_v_front;
    localparam int c_v_sync_end   = c_v_sync_start + c_v_sync;

    localparam int c_coord_w = 10;
    typedef logic [c_coord_w-1:0] coord_t;

    // Widening to int keeps window limits of up to 1024 representable.
    function automatic logic in_window(coord_t v, int lo, int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_delay.sv
`default_nettype none
// ============================================================================
// Module   : sync_delay
// Brief    : Parameterized-depth shift line for sync signals, resets to 1.
// Revision : 1.0 - initial release
// ============================================================================
module sync_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_n};
            assign o_q      = i_d;
        end else begin : g_shift
            logic [DEPTH-1:0] r_stages;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stages <= '1;
                end else begin
                    r_stages[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stages[i] <= r_stages[i-1];
                    end
                end
            end

            assign o_q = r_stages[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Raster counters, blanking, delayed hs/vs and frame markers.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = c_h_visible,
    parameter int H_FRONT    = c_h_front,
    parameter int H_SYNC     = c_h_sync,
    parameter int H_BACK     = c_h_back,
    parameter int V_VISIBLE  = c_v_visible,
    parameter int V_FRONT    = c_v_front,
    parameter int V_SYNC     = c_v_sync,
    parameter int V_BACK     = c_v_back,
    parameter int PIPE_DELAY = 1
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output coord_t      DrawX,
    output coord_t      DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int     c_h_tot    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int     c_v_tot    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int     c_hs_start = H_VISIBLE + H_FRONT;
    localparam int     c_hs_end   = c_hs_start + H_SYNC;
    localparam int     c_vs_start = V_VISIBLE + V_FRONT;
    localparam int     c_vs_end   = c_vs_start + V_SYNC;
    localparam coord_t c_h_last   = coord_t'(c_h_tot - 1);
    localparam coord_t c_v_last   = coord_t'(c_v_tot - 1);

    generate
        if (c_h_tot < 1 || c_h_tot > 1024) begin : g_chk_h_total
            $error("vga_timing_gen: H_TOTAL must be in 1..1024");
        end
        if (c_v_tot < 1 || c_v_tot > 1024) begin : g_chk_v_total
            $error("vga_timing_gen: V_TOTAL must be in 1..1024");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 3) begin : g_chk_pipe
            $error("vga_timing_gen: PIPE_DELAY must be in 0..3");
        end
    endgenerate

    coord_t      r_hc;
    coord_t      r_vc;
    logic        r_blank;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_line_start;
    logic        r_frame_start;
    logic [15:0] r_frame_count;

    coord_t w_hc_next;
    coord_t w_vc_next;
    logic   w_blank_next;
    logic   w_hsync_next;
    logic   w_vsync_next;
    logic   w_line_start_next;
    logic   w_frame_start_next;

    always_comb begin
        w_hc_next = r_hc + coord_t'(1);
        w_vc_next = r_vc;
        if (r_hc == c_h_last) begin
            w_hc_next = '0;
            w_vc_next = (r_vc == c_v_last) ? '0 : r_vc + coord_t'(1);
        end
    end

    // Flags are decoded from the next-state counts so they line up with DrawX/DrawY.
    assign w_blank_next       = in_window(w_hc_next, 0, H_VISIBLE) &&
                                in_window(w_vc_next, 0, V_VISIBLE);
    assign w_hsync_next       = ~in_window(w_hc_next, c_hs_start, c_hs_end);
    assign w_vsync_next       = ~in_window(w_vc_next, c_vs_start, c_vs_end);
    assign w_line_start_next  = (w_hc_next == '0);
    assign w_frame_start_next = w_line_start_next && (w_vc_next == '0);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hc          <= c_h_last;
            r_vc          <= c_v_last;
            r_blank       <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_hc          <= w_hc_next;
            r_vc          <= w_vc_next;
            r_blank       <= w_blank_next;
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
            r_line_start  <= w_line_start_next;
            r_frame_start <= w_frame_start_next;
            if (w_frame_start_next) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    // Extra sync latency matches the drawers' registered RGB path.
    sync_delay #(.DEPTH(PIPE_DELAY)) u_hs_delay (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .i_d   (r_hsync),
        .o_q   (hs)
    );

    sync_delay #(.DEPTH(PIPE_DELAY)) u_vs_delay (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .i_d   (r_vsync),
        .o_q   (vs)
    );

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign blank       = r_blank;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz VGA output path. It produces the `DrawX`/`DrawY`/`blank` stream that every sprite and background drawer consumes. It also produces the `hs`/`vs` sync pulses that go to the connector, delayed so they line up with the drawers' registered RGB. Frame and line markers and a frame counter are exported for animation logic.

## Interface
Parameters:
- `H_VISIBLE`, default 640: visible pixels per line.
- `H_FRONT`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: hsync width, in pixels.
- `H_BACK`, default 48: horizontal back porch. H_TOTAL = 800.
- `V_VISIBLE`, default 480: visible lines per frame.
- `V_FRONT`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vsync width, in lines.
- `V_BACK`, default 33: vertical back porch. V_TOTAL = 525.
- `PIPE_DELAY`, default 1: extra cycles applied to `hs`/`vs` only. Legal range 0..3.

Ports:
- `vga_clk`, input, 1: pixel clock, 25 MHz. This is the only clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `DrawX`, output, 10: current horizontal count, 0..H_TOTAL-1.
- `DrawY`, output, 10: current vertical count, 0..V_TOTAL-1.
- `blank`, output, 1: display enable. 1 = visible pixel (`DrawX` < H_VISIBLE and `DrawY` < V_VISIBLE). Drawers output RGB only when this is 1.
- `hs`, output, 1: horizontal sync, active-low, delayed by PIPE_DELAY.
- `vs`, output, 1: vertical sync, active-low, delayed by PIPE_DELAY.
- `line_start`, output, 1: 1 for the single cycle in which `DrawX` == 0.
- `frame_start`, output, 1: 1 for the single cycle in which `DrawX` == 0 and `DrawY` == 0.
- `frame_count`, output, 16: number of frames started since reset. Wraps modulo 2^16.

## Operation
- Horizontal counter `hc` counts 0..H_TOTAL-1 and wraps to 0.
- Vertical counter `vc` increments only when `hc` wraps, counts 0..V_TOTAL-1, and wraps to 0.
- `DrawX` = `hc` and `DrawY` = `vc`. They keep counting through blanking; they are not clamped.
- All outputs are registers. Each register is loaded from the next-state counter values, so `blank`, `line_start` and `frame_start` are coincident with the `DrawX`/`DrawY` they describe.
- Undelayed sync:
  - hsync is 0 while `hc` is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], which is [656,751] by default.
  - vsync is 0 while `vc` is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], which is [490,491] by default, for whole lines.
  - Both change only alongside counter updates.
- `hs`/`vs` pass through a PIPE_DELAY-stage shift line. This matches drawers that read ROM on the negedge and register RGB on the posedge (1 cycle). With PIPE_DELAY = 0, `hs`/`vs` are coincident with `DrawX`.
- `frame_count` increments in the same cycle `frame_start` asserts.
- Reset state (asynchronous, `reset_n` = 0):
  - `hc` = H_TOTAL-1 and `vc` = V_TOTAL-1, so `DrawX` = 799 and `DrawY` = 524.
  - `blank` = 0, `hs` = 1, `vs` = 1, all delay stages = 1.
  - `line_start` = 0, `frame_start` = 0, `frame_count` = 0.
- Reset asserted mid-frame forces the reset state immediately, regardless of the clock. No partial frame is completed.

## Timing
- First rising edge after `reset_n` deasserts: counters wrap to (0,0). In that cycle `blank` = 1, `line_start` = 1, `frame_start` = 1, and `frame_count` = 1.
- Line period is 800 cycles; frame period is 420000 cycles. `frame_start` pulses exactly every 420000 cycles.
- `blank` is 1 for 640 consecutive cycles per visible line and is 0 for all of lines 480..524.
- The `hs` falling edge occurs PIPE_DELAY cycles after `DrawX` becomes 656. The `hs` rising edge occurs PIPE_DELAY cycles after `DrawX` becomes 752.
- `vs` falls PIPE_DELAY cycles after (`DrawX`,`DrawY`) becomes (0,490). `vs` rises PIPE_DELAY cycles after it becomes (0,492).
- Simultaneous wrap at (799,524) -> (0,0): both counters update on the same edge, and `line_start` and `frame_start` assert together.
- `frame_count` wraps from 0xFFFF to 0x0000 with no extra flag.
- Elaboration checks:
  - H_TOTAL and V_TOTAL must each be <= 1024.
  - PIPE_DELAY must be <= 3.

## Structure
- Shared package `vga_timing_pkg` holds:
  - the default 640x480 timing constants;
  - derived H_TOTAL and V_TOTAL;
  - sync-start and sync-end constants;
  - the `coord_t` 10-bit typedef.
- Drawer modules use the same package for their DrawX/DrawY scaling.
- One sub-module, `sync_delay`: a parameterized-depth shift line with reset value 1, instantiated once per sync signal. Depth 0 degenerates to a wire.

## Test plan
- Reset release: hold `reset_n` low for 5 cycles, then release. Before the first edge, (`DrawX`,`DrawY`) = (799,524) and `hs`/`vs`/`blank` = 1/1/0. After one edge, (0,0) with `blank`, `line_start` and `frame_start` all = 1 and `frame_count` = 1.
- Line timing: run 2 lines. `blank` is high for exactly 640 cycles per line, and `line_start` pulses are 800 cycles apart. With PIPE_DELAY = 1, `hs` is low from `DrawX` = 657 through 752 inclusive (96 cycles).
- Frame timing: run 2 frames. `frame_start` pulses are 420000 cycles apart, `vs` is low for exactly 1600 cycles starting at (1,490), and `frame_count` goes 1 -> 2 -> 3.
- PIPE_DELAY sweep over 0, 1 and 3: the `hs` falling edge lands at `DrawX` = 656, 657 and 659 respectively.
- Mid-frame reset: assert `reset_n` = 0 at (`DrawX`,`DrawY`) = (300,200), asynchronously between edges. Outputs take reset values before the next edge, and after release the frame restarts at (0,0) with `frame_count` = 1.
- Counter wrap: force `frame_count` to 0xFFFF (or run 65536 frames in a fast-parameter build with H_TOTAL = 8 and V_TOTAL = 4). The next `frame_start` yields `frame_count` = 0x0000.
